// File: rtl/gcd_stein_avalon.sv
`default_nettype none
// =============================================================================
// gcd_stein_avalon : binary (Stein) GCD coprocessor on an Avalon-MM slave
// Revision 1.0 - initial release
// =============================================================================
module gcd_stein_avalon #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic        csi_clk,
  input  logic        rsi_reset,
  input  logic [2:0]  avs_s0_address,
  input  logic        avs_s0_read,
  output logic [31:0] avs_s0_readdata,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic        ins_irq0_irq
);

  localparam int         K_W      = $clog2(DATA_W) + 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STRIP  = 2'd1;
  localparam logic [1:0] S_REDUCE = 2'd2;
  localparam logic [7:0] C_ID_W   = 8'(DATA_W);

  logic [1:0]        state_q,    state_d;
  logic [DATA_W-1:0] op_a_q,     op_a_d;
  logic [DATA_W-1:0] op_b_q,     op_b_d;
  logic [DATA_W-1:0] a_q,        a_d;
  logic [DATA_W-1:0] b_q,        b_d;
  logic [DATA_W-1:0] result_q,   result_d;
  logic [K_W-1:0]    k_q,        k_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [CNT_W-1:0]  cycles_q,   cycles_d;
  logic              irq_en_q,   irq_en_d;
  logic              done_q,     done_d;
  logic              zero_err_q, zero_err_d;
  logic              aborted_q,  aborted_d;
  logic              overrun_q,  overrun_d;

  logic             busy;
  logic             wr_ctrl;
  logic             wr_status;
  logic             start_cmd;
  logic             abort_cmd;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_wdata;

  assign busy      = (state_q != S_IDLE);
  assign wr_ctrl   = avs_s0_write && (avs_s0_address == 3'd2);
  assign wr_status = avs_s0_write && (avs_s0_address == 3'd3);
  // ABORT takes precedence over START in the same CTRL write
  assign abort_cmd = wr_ctrl && avs_s0_writedata[1] && busy;
  assign start_cmd = wr_ctrl && avs_s0_writedata[0] && !avs_s0_writedata[1];
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign unused_wdata = ^avs_s0_writedata;

  always_comb begin
    state_d    = state_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    a_d        = a_q;
    b_d        = b_q;
    result_d   = result_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    cycles_d   = cycles_q;
    irq_en_d   = irq_en_q;
    done_d     = done_q;
    zero_err_d = zero_err_q;
    aborted_d  = aborted_q;
    overrun_d  = overrun_q;

    if (avs_s0_write && avs_s0_address == 3'd0) op_a_d = avs_s0_writedata[DATA_W-1:0];
    if (avs_s0_write && avs_s0_address == 3'd1) op_b_d = avs_s0_writedata[DATA_W-1:0];
    if (wr_ctrl) irq_en_d = avs_s0_writedata[2];
    // W1C first so that any hardware set below on this edge overrides it
    if (wr_status) begin
      done_d     = done_q     & ~avs_s0_writedata[1];
      zero_err_d = zero_err_q & ~avs_s0_writedata[2];
      aborted_d  = aborted_q  & ~avs_s0_writedata[3];
      overrun_d  = overrun_q  & ~avs_s0_writedata[4];
    end

    if (abort_cmd) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end else if (busy) begin
      cnt_d = cnt_inc;
      if (start_cmd) overrun_d = 1'b1;
      case (state_q)
        S_STRIP: begin
          if (a_q == '0 || b_q == '0) begin
            result_d = a_q | b_q;
            if (a_q == '0 && b_q == '0) zero_err_d = 1'b1;
            done_d   = 1'b1;
            cycles_d = cnt_inc;
            state_d  = S_IDLE;
          end else if (!a_q[0] && !b_q[0]) begin
            a_d = a_q >> 1;
            b_d = b_q >> 1;
            k_d = k_q + K_W'(1);
          end else begin
            state_d = S_REDUCE;
          end
        end
        S_REDUCE: begin
          if (!a_q[0]) begin
            a_d = a_q >> 1;
          end else if (!b_q[0]) begin
            b_d = b_q >> 1;
          end else if (a_q == b_q) begin
            result_d = a_q << k_q;
            done_d   = 1'b1;
            cycles_d = cnt_inc;
            state_d  = S_IDLE;
          end else if (a_q > b_q) begin
            a_d = (a_q - b_q) >> 1;
          end else begin
            b_d = (b_q - a_q) >> 1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (start_cmd) begin
      a_d        = op_a_q;
      b_d        = op_b_q;
      k_d        = '0;
      cnt_d      = '0;
      done_d     = 1'b0;
      zero_err_d = 1'b0;
      aborted_d  = 1'b0;
      state_d    = S_STRIP;
    end
  end

  always_ff @(posedge csi_clk) begin
    if (rsi_reset) begin
      state_q    <= S_IDLE;
      op_a_q     <= '0;
      op_b_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      cycles_q   <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      zero_err_q <= 1'b0;
      aborted_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      a_q        <= a_d;
      b_q        <= b_d;
      result_q   <= result_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      cycles_q   <= cycles_d;
      irq_en_q   <= irq_en_d;
      done_q     <= done_d;
      zero_err_q <= zero_err_d;
      aborted_q  <= aborted_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    avs_s0_readdata = '0;
    if (avs_s0_read) begin
      case (avs_s0_address)
        3'd0:    avs_s0_readdata = 32'(op_a_q);
        3'd1:    avs_s0_readdata = 32'(op_b_q);
        3'd2:    avs_s0_readdata = {29'b0, irq_en_q, 2'b0};
        3'd3:    avs_s0_readdata = {27'b0, overrun_q, aborted_q, zero_err_q, done_q, busy};
        3'd4:    avs_s0_readdata = 32'(result_q);
        3'd5:    avs_s0_readdata = 32'(cycles_q);
        3'd6:    avs_s0_readdata = {16'h0, 8'h02, C_ID_W};
        default: avs_s0_readdata = '0;
      endcase
    end
  end

  assign ins_irq0_irq = irq_en_q & (done_q | zero_err_q | aborted_q | overrun_q);

endmodule
`default_nettype wire

// File: tb/tb_gcd_stein_avalon.sv
`timescale 1ns/1ps
`default_nettype none
// =============================================================================
// tb_gcd_stein_avalon : directed + random checks against a Euclid reference
// Revision 1.0 - initial release
// =============================================================================
module tb_gcd_stein_avalon;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam int MAX_CYC = 2 * DATA_W + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  addr = '0;
  logic        rd_s = 1'b0;
  logic        wr_s = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  int n_pass = 0;
  int n_chk  = 0;

  gcd_stein_avalon #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .csi_clk          (clk),
    .rsi_reset        (rst),
    .avs_s0_address   (addr),
    .avs_s0_read      (rd_s),
    .avs_s0_readdata  (rdata),
    .avs_s0_write     (wr_s),
    .avs_s0_writedata (wdata),
    .ins_irq0_irq     (irq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] t;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr_s = 1'b1;
    @(posedge clk); #1;
    wr_s = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    addr = a; rd_s = 1'b1;
    #0.1;
    d = rdata;
    rd_s = 1'b0;
  endtask

  // Counts cycles with BUSY observed high; flags a timeout if it never drops
  task automatic wait_idle(output int cyc, output logic tmo);
    logic [31:0] s;
    cyc = 0;
    tmo = 1'b1;
    for (int i = 0; i < 4 * MAX_CYC; i++) begin
      rd(3'd3, s);
      if (s[0]) begin
        cyc++;
        @(posedge clk); #1;
      end else begin
        tmo = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_gcd(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_status, output int cyc);
    logic [31:0] v;
    logic        tmo;
    wr(3'd0, a);
    wr(3'd1, b);
    wr(3'd2, 32'h1);
    wait_idle(cyc, tmo);
    check({tag, " timeout"}, {31'b0, tmo}, 32'h0);
    rd(3'd4, v); check({tag, " result"}, v, ref_gcd(a, b));
    rd(3'd3, v); check({tag, " status"}, v, exp_status);
    rd(3'd5, v); check({tag, " cycles==busy"}, v, 32'(cyc));
    check({tag, " cycles bound"}, {31'b0, (cyc <= MAX_CYC)}, 32'h1);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] ra, rb, m, prev_res, prev_cyc;
    logic        tmo;
    int          cyc;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check($sformatf("reset addr%0d", i), v, (i == 6) ? 32'h0000_0220 : 32'h0);
    end
    check("reset irq", {31'b0, irq}, 32'h0);
    addr = 3'd6; #0.1;
    check("readdata without read", rdata, 32'h0);

    wr(3'd0, 32'd12);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'h1);
    rd(3'd3, v); check("12,8 busy next cycle", v, 32'h1);
    wait_idle(cyc, tmo);
    check("12,8 timeout", {31'b0, tmo}, 32'h0);
    check("12,8 busy cycles", 32'(cyc), 32'd6);
    rd(3'd4, v); check("12,8 result", v, 32'd4);
    rd(3'd5, v); check("12,8 cycles", v, 32'd6);
    rd(3'd3, v); check("12,8 status", v, 32'h2);

    run_gcd("0,0", 32'd0, 32'd0, 32'h6, cyc);
    check("0,0 cycles", 32'(cyc), 32'd1);
    run_gcd("0,9", 32'd0, 32'd9, 32'h2, cyc);
    run_gcd("ffffffff,fffffffe", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h2, cyc);
    run_gcd("80000000 x2", 32'h8000_0000, 32'h8000_0000, 32'h2, cyc);

    for (int i = 0; i < 16; i++) begin
      m  = 32'($urandom_range(1, 255)) << $urandom_range(0, 12);
      ra = (i % 2 == 0) ? $urandom : m * 32'($urandom_range(0, 4000));
      rb = (i % 2 == 0) ? $urandom : m * 32'($urandom_range(1, 4000));
      run_gcd($sformatf("rand%0d %0h,%0h", i, ra, rb), ra, rb, 32'h2, cyc);
    end

    // W1C of DONE on the very edge the engine sets it: the set must survive
    wr(3'd0, 32'd12);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'h1);
    repeat (5) @(posedge clk);
    #1;
    wr(3'd3, 32'h2);
    rd(3'd3, v); check("w1c vs set", v, 32'h2);

    wr(3'd0, 32'd1071);
    wr(3'd1, 32'd462);
    wr(3'd2, 32'h1);
    wr(3'd0, 32'd5);
    wr(3'd2, 32'h1);
    wait_idle(cyc, tmo);
    check("overrun timeout", {31'b0, tmo}, 32'h0);
    rd(3'd4, v); check("overrun snapshot result", v, 32'd21);
    rd(3'd3, v); check("overrun status", v, 32'h12);
    rd(3'd0, v); check("overrun op_a rewritten", v, 32'd5);
    wr(3'd3, 32'h10);
    rd(3'd3, v); check("overrun w1c", v, 32'h2);

    rd(3'd4, prev_res);
    rd(3'd5, prev_cyc);
    wr(3'd0, 32'd1071);
    wr(3'd2, 32'h1);
    repeat (2) @(posedge clk);
    #1;
    wr(3'd2, 32'h3);
    rd(3'd3, v); check("abort status", v, 32'h8);
    rd(3'd4, v); check("abort result kept", v, prev_res);
    rd(3'd5, v); check("abort cycles kept", v, prev_cyc);
    wr(3'd2, 32'h2);
    rd(3'd3, v); check("abort in idle", v, 32'h8);

    wr(3'd2, 32'h4);
    rd(3'd2, v); check("ctrl irq_en", v, 32'h4);
    check("irq on aborted", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h1E);
    check("irq after clear", {31'b0, irq}, 32'h0);
    wr(3'd0, 32'd12);
    wr(3'd1, 32'd8);
    wr(3'd2, 32'h5);
    wait_idle(cyc, tmo);
    check("irq run timeout", {31'b0, tmo}, 32'h0);
    check("irq on done", {31'b0, irq}, 32'h1);
    wr(3'd3, 32'h1E);
    check("irq cleared", {31'b0, irq}, 32'h0);
    rd(3'd3, v); check("status cleared", v, 32'h0);

    wr(3'd0, 32'd1071);
    wr(3'd1, 32'd462);
    wr(3'd2, 32'h5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check($sformatf("midrun reset addr%0d", i), v, (i == 6) ? 32'h0000_0220 : 32'h0);
    end
    repeat (MAX_CYC) @(posedge clk);
    #1;
    rd(3'd3, v); check("no done after reset", v, 32'h0);
    check("irq after reset", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
